// File: rtl/run_length_counter.sv
// ----------------------------------------------------------------------------
// run_length_counter
//
// Measures how long a qualified level stays high. It keeps three results:
//   * oCOUNT   - main count. In mode 0 it counts the current high run and
//                returns to 0 when the input goes low. In mode 1 it keeps
//                accumulating high cycles and holds while the input is low.
//   * oRUN_LEN - length of the most recently completed high run. It is valid
//                on the cycle that oRUN_VALID pulses.
//   * oTHRESH_HIT / oSAT - pulse when oCOUNT arrives at iTHRESH, and a level
//                that stays high while oCOUNT sits at all-ones.
// Every counter saturates at 2^WIDTH-1. None of them wrap.
//
// Optional build feature: define RUN_PEAK_EN to add oPEAK. oPEAK is the
// longest completed run seen since the last reset or clear.
//
// Parameters:
//   WIDTH        - width of all counters, iTHRESH, oCOUNT, oRUN_LEN (, oPEAK)
//   MODE_DEFAULT - documents the intended mode when iMODE is tied low
//                  (0 or 1). iMODE is always the live control.
//
// Ports:
//   iCLK        in   clock, rising edge
//   iRST        in   asynchronous active-low reset
//   iSIGNAL     in   qualified level being measured
//   iCLEAR      in   synchronous clear of counters and pulses (oRUN_LEN kept)
//   iMODE       in   0 = per-run count, 1 = accumulate (hold while low)
//   iTHRESH     in   threshold for oTHRESH_HIT. A value of 0 disables it.
//   oCOUNT      out  main count
//   oRUN_LEN    out  length of the last completed high run
//   oRUN_VALID  out  one-cycle pulse, oRUN_LEN updated this cycle
//   oTHRESH_HIT out  one-cycle pulse when oCOUNT becomes equal to iTHRESH
//   oPEAK       out  longest completed run (RUN_PEAK_EN builds only)
//   oSAT        out  high while oCOUNT == 2^WIDTH-1
// ----------------------------------------------------------------------------
module run_length_counter #(
  parameter int unsigned WIDTH        = 10,
  parameter int unsigned MODE_DEFAULT = 0
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iSIGNAL,
  input  logic             iCLEAR,
  input  logic             iMODE,
  input  logic [WIDTH-1:0] iTHRESH,
  output logic [WIDTH-1:0] oCOUNT,
  output logic [WIDTH-1:0] oRUN_LEN,
  output logic             oRUN_VALID,
  output logic             oTHRESH_HIT,
`ifdef RUN_PEAK_EN
  output logic [WIDTH-1:0] oPEAK,
`endif
  output logic             oSAT
);

  // Elaboration-time sanity check on the documented default mode.
  if (MODE_DEFAULT > 1) begin : g_bad_mode_default
    $error("run_length_counter: MODE_DEFAULT must be 0 or 1");
  end

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] count_q,      count_d;      // main count (oCOUNT)
  logic [WIDTH-1:0] run_q,        run_d;        // current high-run length
  logic             sig_dly_q,    sig_dly_d;    // iSIGNAL from previous edge
  logic [WIDTH-1:0] run_len_q,    run_len_d;    // last completed run
  logic             run_valid_q,  run_valid_d;
  logic             thresh_hit_q, thresh_hit_d;
  logic             sat_q,        sat_d;
`ifdef RUN_PEAK_EN
  logic [WIDTH-1:0] peak_q,       peak_d;
`endif

  // Saturating increments, shared by the clear and non-clear paths.
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] run_inc;
  logic             run_end;

  assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
  assign run_inc   = (run_q   == CNT_MAX) ? run_q   : run_q   + CNT_ONE;

  // A run has ended when the previous sample was high and this one is low.
  // The run counter still holds the number of high cycles at this point.
  assign run_end   = sig_dly_q & ~iSIGNAL;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default value before any branch. This keeps
    // the block purely combinational, so no latch is inferred on a path
    // that misses an assignment.
    count_d      = count_q;
    run_d        = run_q;
    sig_dly_d    = sig_dly_q;
    run_len_d    = run_len_q;
    run_valid_d  = 1'b0;
    thresh_hit_d = 1'b0;
`ifdef RUN_PEAK_EN
    peak_d       = peak_q;
`endif

    if (iCLEAR) begin
      // A run cut short by clear is dropped. It is not reported, and the
      // last reported length is kept.
      count_d   = '0;
      run_d     = '0;
      sig_dly_d = 1'b0;
`ifdef RUN_PEAK_EN
      peak_d    = '0;
`endif
    end else begin
      // Main count: increment while high. When low, mode 0 returns to zero
      // and mode 1 holds the accumulated total.
      if (iSIGNAL) begin
        count_d = count_inc;
      end else if (!iMODE) begin
        count_d = '0;
      end

      // The run counter always follows per-run behaviour, whatever iMODE is.
      run_d     = iSIGNAL ? run_inc : '0;
      sig_dly_d = iSIGNAL;

      if (run_end) begin
        run_len_d   = run_q;
        run_valid_d = 1'b1;
`ifdef RUN_PEAK_EN
        if (run_q > peak_q) begin
          peak_d = run_q;
        end
`endif
      end

      // The pulse fires only on arrival at the threshold. Sitting on the
      // threshold (mode-1 hold, or saturation at iTHRESH == max) does not
      // re-fire. Leaving the threshold re-arms it.
      thresh_hit_d = (iTHRESH != '0) && (count_d == iTHRESH) &&
                     (count_q != iTHRESH);
    end

    // Computed from the next count, so oSAT lines up with oCOUNT. Clear
    // forces count_d to 0, which releases oSAT as well.
    sat_d = (count_d == CNT_MAX);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      count_q      <= '0;
      run_q        <= '0;
      sig_dly_q    <= 1'b0;
      run_len_q    <= '0;
      run_valid_q  <= 1'b0;
      thresh_hit_q <= 1'b0;
      sat_q        <= 1'b0;
`ifdef RUN_PEAK_EN
      peak_q       <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All flops then
      // sample the values from before the edge, whatever order they are
      // written in.
      count_q      <= count_d;
      run_q        <= run_d;
      sig_dly_q    <= sig_dly_d;
      run_len_q    <= run_len_d;
      run_valid_q  <= run_valid_d;
      thresh_hit_q <= thresh_hit_d;
      sat_q        <= sat_d;
`ifdef RUN_PEAK_EN
      peak_q       <= peak_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all registered)
  // --------------------------------------------------------------------------
  assign oCOUNT      = count_q;
  assign oRUN_LEN    = run_len_q;
  assign oRUN_VALID  = run_valid_q;
  assign oTHRESH_HIT = thresh_hit_q;
  assign oSAT        = sat_q;
`ifdef RUN_PEAK_EN
  assign oPEAK       = peak_q;
`endif

endmodule

// File: tb/tb_run_length_counter.sv
// ----------------------------------------------------------------------------
// tb_run_length_counter
//
// Runs directed scenarios and then randomized level/mode/clear/threshold
// traffic on run_length_counter with WIDTH=10. After every clock edge, all
// outputs are compared with a behavioural model. The model tracks integer
// run lengths and totals and applies saturation only where the value is
// observed.
// ----------------------------------------------------------------------------
module tb_run_length_counter;

  localparam int W   = 10;
  localparam int MAX = (1 << W) - 1;

  logic         iCLK = 1'b0;
  logic         iRST;
  logic         iSIGNAL;
  logic         iCLEAR;
  logic         iMODE;
  logic [W-1:0] iTHRESH;
  logic [W-1:0] oCOUNT;
  logic [W-1:0] oRUN_LEN;
  logic         oRUN_VALID;
  logic         oTHRESH_HIT;
  logic         oSAT;
`ifdef RUN_PEAK_EN
  logic [W-1:0] oPEAK;
`endif

  run_length_counter #(.WIDTH(W), .MODE_DEFAULT(0)) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iSIGNAL     (iSIGNAL),
    .iCLEAR      (iCLEAR),
    .iMODE       (iMODE),
    .iTHRESH     (iTHRESH),
    .oCOUNT      (oCOUNT),
    .oRUN_LEN    (oRUN_LEN),
    .oRUN_VALID  (oRUN_VALID),
    .oTHRESH_HIT (oTHRESH_HIT),
`ifdef RUN_PEAK_EN
    .oPEAK       (oPEAK),
`endif
    .oSAT        (oSAT)
  );

  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_fail   = 0;
  int hit_pulses;
  int valid_pulses;

  // Reference model state. The high-run length is kept as an unbounded
  // integer and only clipped to MAX when it is reported.
  int m_count, m_run_raw, m_run_len, m_peak;
  bit m_prev_sig, m_valid, m_hit, m_sat;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int clip(input int v);
    return (v > MAX) ? MAX : v;
  endfunction

  task automatic model_reset();
    m_count = 0; m_run_raw = 0; m_run_len = 0; m_peak = 0;
    m_prev_sig = 0; m_valid = 0; m_hit = 0; m_sat = 0;
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_edge(input bit sig, input bit clr, input bit mode,
                            input int thr);
    int old_count;
    old_count = m_count;
    if (clr) begin
      m_count = 0; m_run_raw = 0; m_prev_sig = 0;
      m_valid = 0; m_hit = 0; m_peak = 0;
    end else begin
      if (sig)       m_count = clip(m_count + 1);
      else if (!mode) m_count = 0;
      m_valid = m_prev_sig && !sig;
      if (m_valid) begin
        m_run_len = clip(m_run_raw);
        if (m_run_len > m_peak) m_peak = m_run_len;
      end
      m_run_raw  = sig ? m_run_raw + 1 : 0;
      m_prev_sig = sig;
      m_hit = (thr != 0) && (m_count == thr) && (old_count != thr);
    end
    m_sat = (m_count == MAX);
  endtask

  task automatic compare_all();
    check("count",     oCOUNT,      m_count);
    check("run_len",   oRUN_LEN,    m_run_len);
    check("run_valid", oRUN_VALID,  m_valid);
    check("thr_hit",   oTHRESH_HIT, m_hit);
    check("sat",       oSAT,        m_sat);
`ifdef RUN_PEAK_EN
    check("peak",      oPEAK,       m_peak);
`endif
  endtask

  // Drive inputs just after an edge, clock once, then compare 1 ns later.
  task automatic cycle(input bit sig, input bit clr, input bit mode,
                       input int thr);
    iSIGNAL = sig; iCLEAR = clr; iMODE = mode; iTHRESH = W'(thr);
    @(posedge iCLK);
    model_edge(sig, clr, mode, thr);
    #1;
    compare_all();
    if (oTHRESH_HIT) hit_pulses++;
    if (oRUN_VALID)  valid_pulses++;
  endtask

  task automatic run_n(input int n, input bit sig, input bit mode,
                       input int thr);
    for (int i = 0; i < n; i++) cycle(sig, 1'b0, mode, thr);
  endtask

  initial begin
    bit sig, mode, clr;
    int thr;

    iRST = 1'b0; iSIGNAL = 0; iCLEAR = 0; iMODE = 0; iTHRESH = '0;
    model_reset();
    hit_pulses = 0; valid_pulses = 0;
    #12;
    compare_all();                       // outputs held in reset
    @(negedge iCLK) iRST = 1'b1;

    // Idle after reset: everything stays 0.
    run_n(5, 1'b0, 1'b0, 0);
    check("idle_pulses", valid_pulses + hit_pulses, 0);

    // Mode 0, 7-cycle run.
    valid_pulses = 0;
    for (int i = 1; i <= 7; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 0);
      check("m0_ramp", oCOUNT, i);
    end
    run_n(2, 1'b0, 1'b0, 0);
    check("m0_len7", oRUN_LEN, 7);
    check("m0_one_valid", valid_pulses, 1);
    check("m0_back0", oCOUNT, 0);

    // Mode 1: runs of 3 and 4 with a 2-cycle gap.
    run_n(3, 1'b1, 1'b1, 0);
    run_n(1, 1'b0, 1'b1, 0);
    check("m1_len3", oRUN_LEN, 3);
    run_n(1, 1'b0, 1'b1, 0);
    check("m1_hold3", oCOUNT, 3);
    run_n(4, 1'b1, 1'b1, 0);
    run_n(1, 1'b0, 1'b1, 0);
    check("m1_total7", oCOUNT, 7);
    check("m1_len4", oRUN_LEN, 4);
    cycle(1'b0, 1'b1, 1'b1, 0);          // clear the accumulator

    // Threshold 5, mode 0, 8 high: exactly one pulse. Then threshold 0: none.
    hit_pulses = 0;
    run_n(8, 1'b1, 1'b0, 5);
    run_n(2, 1'b0, 1'b0, 5);
    check("thr5_pulses", hit_pulses, 1);
    hit_pulses = 0;
    run_n(8, 1'b1, 1'b0, 0);
    run_n(2, 1'b0, 1'b0, 0);
    check("thr0_pulses", hit_pulses, 0);

    // Mode 1 sitting on the threshold must not re-fire.
    hit_pulses = 0;
    run_n(3, 1'b1, 1'b1, 3);
    run_n(3, 1'b0, 1'b1, 3);
    check("thr_hold_pulses", hit_pulses, 1);
    cycle(1'b0, 1'b1, 1'b0, 0);

    // Saturation: 1030 high cycles.
    run_n(1030, 1'b1, 1'b0, 0);
    check("sat_count", oCOUNT, MAX);
    check("sat_flag", oSAT, 1);
    run_n(1, 1'b0, 1'b0, 0);
    check("sat_len", oRUN_LEN, MAX);
    check("sat_release", oSAT, 0);

    // Clear at count 4 while high: no report, counting resumes from 1.
    valid_pulses = 0;
    run_n(4, 1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b0, 0);
    check("clr_count0", oCOUNT, 0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    check("clr_resume1", oCOUNT, 1);
    check("clr_no_valid", valid_pulses, 0);
    run_n(1, 1'b0, 1'b0, 0);
    check("clr_len_after", oRUN_LEN, 1);

    // Asynchronous reset pulsed mid-run, between edges.
    run_n(3, 1'b1, 1'b0, 0);
    #2 iRST = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge iCLK) iRST = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 0);
    check("rst_resume1", oCOUNT, 1);
    run_n(1, 1'b0, 1'b0, 0);

    // Peak tracking across runs 6 and 2 after a clear.
    cycle(1'b0, 1'b1, 1'b0, 0);
    run_n(6, 1'b1, 1'b0, 0);
    run_n(1, 1'b0, 1'b0, 0);
    run_n(2, 1'b1, 1'b0, 0);
    run_n(1, 1'b0, 1'b0, 0);
    check("runs62_len", oRUN_LEN, 2);
`ifdef RUN_PEAK_EN
    check("peak6", oPEAK, 6);
`endif

    // Randomized traffic.
    sig = 0; mode = 0; thr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 20)  sig  = ~sig;
      if ($urandom_range(0, 99) < 4)   mode = ~mode;
      if ($urandom_range(0, 99) < 3)   thr  = $urandom_range(0, 24);
      clr = ($urandom_range(0, 99) < 2);
      cycle(sig, clr, mode, thr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/run_length_counter.md
Name: run_length_counter

Overview:
Parametrised successor to the single-width consecutive-high counter used in the ProCam capture path. Counts cycles that iSIGNAL is high, either as a per-run count (MODE 0) or as a running total (MODE 1). Also reports each completed run length, pulses when a programmable threshold is reached, and saturates instead of wrapping. Used for sync-pulse width measurement, exposure/line-length checks and debounce qualification.

Parameters:
WIDTH, 10, bit width of every counter and of iTHRESH/oCOUNT/oRUN_LEN
MODE_DEFAULT, 0, value of the internal mode when iMODE is tied low (informational; iMODE is the live control)

Ports:
iCLK  in  1  clock, rising edge
iRST  in  1  asynchronous active-low reset
iSIGNAL  in  1  qualified input level being measured
iCLEAR  in  1  synchronous clear of all counters and flags
iMODE  in  1  0 = oCOUNT resets when iSIGNAL low; 1 = oCOUNT holds when low (accumulate)
iTHRESH  in  WIDTH  threshold for oTHRESH_HIT; 0 = disabled
oCOUNT  out  WIDTH  main count (mode dependent)
oRUN_LEN  out  WIDTH  length of last completed high run
oRUN_VALID  out  1  one-cycle pulse, oRUN_LEN updated this cycle
oTHRESH_HIT  out  1  one-cycle pulse when oCOUNT becomes equal to iTHRESH
oSAT  out  1  high while oCOUNT == 2^WIDTH-1

Behaviour:
- Reset (iRST=0, async): oCOUNT, oRUN_LEN, internal run counter, sig_d = 0; oRUN_VALID, oTHRESH_HIT, oSAT = 0.
- All outputs registered; one-cycle latency from sampled iSIGNAL to oCOUNT.
- Priority per edge: iCLEAR > count/hold logic.
- iCLEAR=1: oCOUNT, run counter, sig_d <= 0; oRUN_VALID and oTHRESH_HIT <= 0 (a run interrupted by clear is not reported); oRUN_LEN retains its value.
- oCOUNT next value:
  - iSIGNAL=1: oCOUNT+1, unless oCOUNT == 2^WIDTH-1, then hold (no wrap).
  - iSIGNAL=0, iMODE=0: 0.
  - iSIGNAL=0, iMODE=1: hold.
- Internal run counter: always MODE-0 behaviour (increment while high, saturating; 0 when low).
- Run end: edge with sig_d=1 and iSIGNAL=0 -> oRUN_LEN <= run counter value (number of high cycles, saturated at max) and oRUN_VALID <= 1 for that cycle only. sig_d <= iSIGNAL every non-clear edge.
- Threshold: oTHRESH_HIT <= 1 iff iTHRESH != 0 and next oCOUNT == iTHRESH and current oCOUNT != iTHRESH. It fires once per approach, and is re-armed after oCOUNT leaves the threshold. In MODE 1, holding at the threshold does not re-fire.
- oSAT <= (next oCOUNT == 2^WIDTH-1). It clears when oCOUNT returns to 0 (low in MODE 0, or clear).
- iMODE change mid-run takes effect on the next edge. The current oCOUNT value is kept, with no reset.
- Run length of 1 (single high cycle) is reported as oRUN_LEN=1.

Optional Feature:
RUN_PEAK_EN: when defined, adds output oPEAK [WIDTH-1:0]. oPEAK is reset to 0 by iRST or iCLEAR. On each oRUN_VALID edge, oPEAK <= max(oPEAK, completed run length). When the macro is undefined, the port and logic are absent and the other behaviour is identical.

Test Plan:
- Reset release, iSIGNAL=0 for 5 cycles -> all outputs 0, no pulses.
- WIDTH=10, MODE 0, iSIGNAL high 7 cycles then low -> oCOUNT 1..7 then 0; oRUN_VALID one pulse with oRUN_LEN=7.
- MODE 1, runs of 3 and 4 separated by 2 low cycles -> oCOUNT holds 3 during the gap and ends at 7; oRUN_LEN 3 then 4.
- iTHRESH=5, MODE 0, high 8 cycles -> oTHRESH_HIT exactly one pulse, on the edge oCOUNT becomes 5; iTHRESH=0 -> no pulse.
- iSIGNAL high 1030 cycles -> oCOUNT stops at 1023 and oSAT=1 from that edge; on low, oRUN_LEN=1023, oCOUNT=0 and oSAT=0.
- iCLEAR asserted at count 4 while high, and also iRST pulsed mid-run -> counters go to 0 with no oRUN_VALID; counting resumes from 1; with RUN_PEAK_EN, oPEAK tracks 6 after runs 6,2.
